// File: rtl/shift_issue_stage.sv
// Issue stage feeding the barrel shifter: decodes RV32I shifts and registers them
// behind a 2-entry skid buffer so in_ready never depends combinationally on out_ready.
module shift_issue_stage #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [1:0]      out_h_select,
  output logic [4:0]      out_shamt,
  output logic [RD_W-1:0] out_rd,
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [1:0]      h_select;
    logic [4:0]      shamt;
    logic [RD_W-1:0] rd;
    logic            illegal;
  } entry_t;

  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] OPC_REG = 7'b0110011;

  entry_t dec, main_q, skid_q;
  logic   main_v, skid_v;
  logic   accept, drain;

  always_comb begin
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic       is_op;
    opc          = in_instr[6:0];
    f3           = in_instr[14:12];
    f7           = in_instr[31:25];
    is_op        = (opc == OPC_IMM) || (opc == OPC_REG);
    dec          = '0;
    dec.a        = in_rs1_data;
    dec.rd       = in_instr[7 +: RD_W];
    dec.illegal  = 1'b1;
    if (is_op) begin
      if (f3 == 3'b001 && f7 == 7'b0000000) begin
        dec.illegal  = 1'b0;
        dec.h_select = 2'd0;
      end else if (f3 == 3'b101 && f7 == 7'b0000000) begin
        dec.illegal  = 1'b0;
        dec.h_select = 2'd1;
      end else if (f3 == 3'b101 && f7 == 7'b0100000) begin
        dec.illegal  = 1'b0;
        dec.h_select = 2'd3;
      end
    end
    if (!dec.illegal)
      dec.shamt = (opc == OPC_IMM) ? in_instr[24:20] : in_rs2_data[4:0];
  end

  assign in_ready = ~skid_v;
  assign accept   = in_valid & in_ready;
  assign drain    = main_v & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      // Payloads keep stale data; only the valids are cleared.
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (skid_v) begin
      if (drain) begin
        main_q <= skid_q;
        skid_v <= 1'b0;
      end
    end else if (!main_v || drain) begin
      main_v <= accept;
      if (accept) main_q <= dec;
    end else if (accept) begin
      skid_q <= dec;
      skid_v <= 1'b1;
    end
  end

  assign out_valid    = main_v;
  assign out_a        = main_q.a;
  assign out_h_select = main_q.h_select;
  assign out_shamt    = main_q.shamt;
  assign out_rd       = main_q.rd;
  assign out_illegal  = main_q.illegal;

endmodule
